// File: rtl/bitstream_loader.sv
// ---------------------------------------------------------------------------
// bitstream_loader
//   Configuration-side driver for the CLB programming chain. It accepts
//   configuration words over a valid/ready stream and shifts them LSB-first
//   onto prog_in. prog_en qualifies each bit. Exactly CHAIN_LEN bits are
//   issued per load. Upper bits of the final word beyond LAST_BITS are
//   discarded.
//
//   Optional build macro: PROG_READBACK_EN
//     When this macro is defined, the block captures the previous chain
//     contents as they emerge on prog_out. It packs them LSB-first into
//     rb_data and marks each completed word with rb_valid.
//
// Ports
//   prog_clk   in   clock; all logic on the rising edge
//   prog_rst   in   synchronous active-high reset
//   start      in   single-cycle request to begin a full chain load
//   cfg_data   in   configuration word, bit 0 shifted first
//   cfg_valid  in   cfg_data is valid
//   cfg_ready  out  loader accepts a word this cycle (state decode)
//   prog_in    out  serial bit to the chain (registered)
//   prog_en    out  chain shift enable (registered)
//   prog_out   in   serial output of the chain tail (readback only)
//   rb_data    out  readback word          (PROG_READBACK_EN only)
//   rb_valid   out  readback word strobe   (PROG_READBACK_EN only)
//   busy       out  load in progress
//   done       out  last load completed (level)
// ---------------------------------------------------------------------------
module bitstream_loader #(
  parameter int unsigned CHAIN_LEN = 1024,
  parameter int unsigned WORD_W    = 32
) (
  input  logic              prog_clk,
  input  logic              prog_rst,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              prog_in,
  output logic              prog_en,
  input  logic              prog_out,
`ifdef PROG_READBACK_EN
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
`endif
  output logic              busy,
  output logic              done
);

  localparam int unsigned NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int unsigned LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
  localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WC_W      = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned BI_W      = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state,    w_state;
  logic [WORD_W-1:0]   r_sreg,     w_sreg;
  logic [BI_W-1:0]     r_bit_idx,  w_bit_idx;
  logic [WC_W-1:0]     r_word_cnt, w_word_cnt;
  logic [CNT_W-1:0]    r_bit_cnt,  w_bit_cnt;
  logic                r_prog_in,  w_prog_in;
  logic                r_prog_en,  w_prog_en;

  logic                w_last_word;
  logic [BI_W-1:0]     w_word_len_m1;
  logic                w_can_issue;

  // Current word geometry; the final word may be short.
  assign w_last_word   = (r_word_cnt == WC_W'(NWORDS - 1));
  assign w_word_len_m1 = w_last_word ? BI_W'(LAST_BITS - 1) : BI_W'(WORD_W - 1);
  // Hard cap: never more than CHAIN_LEN enables per load.
  assign w_can_issue   = (r_bit_cnt != CNT_W'(CHAIN_LEN));

  // Next-state and bit-issue logic.
  always_comb begin
    w_state    = r_state;
    w_sreg     = r_sreg;
    w_bit_idx  = r_bit_idx;
    w_word_cnt = r_word_cnt;
    w_bit_cnt  = r_bit_cnt;
    w_prog_in  = r_prog_in;
    w_prog_en  = 1'b0;

    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state    = S_LOAD;
          w_bit_cnt  = '0;
          w_word_cnt = '0;
          w_bit_idx  = '0;
        end
      end

      S_LOAD: begin
        if (cfg_valid && w_can_issue) begin
          // Bit 0 goes out on the handshake edge; the rest stay in sreg.
          w_sreg    = cfg_data >> 1;
          w_prog_in = cfg_data[0];
          w_prog_en = 1'b1;
          w_bit_cnt = r_bit_cnt + 1'b1;
          if (w_word_len_m1 == '0) begin
            if (w_last_word) begin
              w_state = S_DONE;
            end else begin
              w_word_cnt = r_word_cnt + 1'b1;
            end
          end else begin
            w_state   = S_SHIFT;
            w_bit_idx = BI_W'(1);
          end
        end
      end

      S_SHIFT: begin
        w_prog_in = r_sreg[0];
        w_prog_en = w_can_issue;
        w_sreg    = r_sreg >> 1;
        w_bit_idx = r_bit_idx + 1'b1;
        if (w_can_issue) begin
          w_bit_cnt = r_bit_cnt + 1'b1;
        end
        if ((r_bit_idx == w_word_len_m1) || !w_can_issue) begin
          w_bit_idx = '0;
          if (w_last_word || !w_can_issue) begin
            w_state = S_DONE;
          end else begin
            w_state    = S_LOAD;
            w_word_cnt = r_word_cnt + 1'b1;
          end
        end
      end

      default: w_state = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge prog_clk) begin
    if (prog_rst) begin
      r_state    <= S_IDLE;
      r_sreg     <= '0;
      r_bit_idx  <= '0;
      r_word_cnt <= '0;
      r_bit_cnt  <= '0;
      r_prog_in  <= 1'b0;
      r_prog_en  <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_sreg     <= w_sreg;
      r_bit_idx  <= w_bit_idx;
      r_word_cnt <= w_word_cnt;
      r_bit_cnt  <= w_bit_cnt;
      r_prog_in  <= w_prog_in;
      r_prog_en  <= w_prog_en;
    end
  end

  assign cfg_ready = (r_state == S_LOAD);
  assign busy      = (r_state == S_LOAD) || (r_state == S_SHIFT);
  assign done      = (r_state == S_DONE);
  assign prog_in   = r_prog_in;
  assign prog_en   = r_prog_en;

`ifdef PROG_READBACK_EN
  logic [WORD_W-1:0] r_rb_acc;
  logic [WORD_W-1:0] r_rb_data;
  logic              r_rb_valid;
  logic [BI_W-1:0]   r_rb_cnt;
  logic [WC_W-1:0]   r_rb_word;
  logic              w_rb_last;
  logic [BI_W-1:0]   w_rb_len_m1;
  logic [WORD_W-1:0] w_rb_bit;

  assign w_rb_last   = (r_rb_word == WC_W'(NWORDS - 1));
  assign w_rb_len_m1 = w_rb_last ? BI_W'(LAST_BITS - 1) : BI_W'(WORD_W - 1);
  assign w_rb_bit    = WORD_W'(prog_out) << r_rb_cnt;

  // Capture the tail bit on every edge where the chain shifts. A full pass
  // always leaves the counters at zero, so a new load needs no extra clear.
  always_ff @(posedge prog_clk) begin
    if (prog_rst) begin
      r_rb_acc   <= '0;
      r_rb_data  <= '0;
      r_rb_valid <= 1'b0;
      r_rb_cnt   <= '0;
      r_rb_word  <= '0;
    end else begin
      r_rb_valid <= 1'b0;
      if (r_prog_en) begin
        if (r_rb_cnt == w_rb_len_m1) begin
          r_rb_data  <= r_rb_acc | w_rb_bit;
          r_rb_valid <= 1'b1;
          r_rb_acc   <= '0;
          r_rb_cnt   <= '0;
          r_rb_word  <= w_rb_last ? '0 : (r_rb_word + 1'b1);
        end else begin
          r_rb_acc <= r_rb_acc | w_rb_bit;
          r_rb_cnt <= r_rb_cnt + 1'b1;
        end
      end
    end
  end

  assign rb_data  = r_rb_data;
  assign rb_valid = r_rb_valid;
`else
  logic w_unused_prog_out;
  assign w_unused_prog_out = prog_out;
`endif

endmodule

// File: tb/tb_bitstream_loader.sv
// ---------------------------------------------------------------------------
// tb_bitstream_loader
//   Bench for bitstream_loader with CHAIN_LEN=40 and WORD_W=32. A behavioural
//   chain model shifts on prog_en and feeds prog_out. A per-cycle log of the
//   DUT outputs is analysed after each load against the word-level
//   expectation. That expectation includes the bit order, the enable count,
//   the gaps, the busy/done levels, the final chain contents and, when
//   PROG_READBACK_EN is defined, the readback words.
// ---------------------------------------------------------------------------
module tb_bitstream_loader;

  localparam int unsigned CL  = 40;
  localparam int unsigned WW  = 32;
  localparam int unsigned LB  = 8;
  localparam int          LIM = 300;

  logic          clk = 1'b0;
  logic          prog_rst;
  logic          start;
  logic [WW-1:0] cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          prog_in;
  logic          prog_en;
  logic          prog_out;
  logic          busy;
  logic          done;
`ifdef PROG_READBACK_EN
  logic [WW-1:0] rb_data;
  logic          rb_valid;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bitstream_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .prog_clk  (clk),
    .prog_rst  (prog_rst),
    .start     (start),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .prog_in   (prog_in),
    .prog_en   (prog_en),
    .prog_out  (prog_out),
`ifdef PROG_READBACK_EN
    .rb_data   (rb_data),
    .rb_valid  (rb_valid),
`endif
    .busy      (busy),
    .done      (done)
  );

  // Chain model: shifts in prog_in on enabled edges, tail drives prog_out.
  logic [CL-1:0] chain;
  logic [CL-1:0] chain_init;
  logic          chain_load;
  assign prog_out = chain[CL-1];

  always @(posedge clk) begin
    if (chain_load) chain <= chain_init;
    else if (prog_en) chain <= {chain[CL-2:0], prog_in};
  end

  // Per-cycle output log, sampled mid-cycle.
  logic q_en[$];
  logic q_in[$];
  logic q_busy[$];
  logic [WW-1:0] q_rb[$];

  always @(negedge clk) begin
    q_en.push_back(prog_en);
    q_in.push_back(prog_in);
    q_busy.push_back(busy);
`ifdef PROG_READBACK_EN
    if (rb_valid) q_rb.push_back(rb_data);
`endif
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Present one word; g>0 holds cfg_valid low for g LOAD cycles first.
  task automatic send_word(input logic [WW-1:0] w, input int g);
    int t;
    if (g > 0) begin
      cfg_valid = 1'b0;
      @(negedge clk);
      t = 0;
      while (!cfg_ready && t < LIM) begin @(negedge clk); t++; end
      repeat (g) @(negedge clk);
    end else begin
      @(negedge clk);
    end
    cfg_data  = w;
    cfg_valid = 1'b1;
    t = 0;
    while (!cfg_ready && t < LIM) begin @(negedge clk); t++; end
    check("cfg_handshake", 64'(cfg_ready), 64'(1));
    @(posedge clk);
    #1;
  endtask

  // One full load of two words, analysed against the word-level model.
  task automatic do_load(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                         input int g1, input bit mid_start,
                         output logic [WW-1:0] rb0, output logic [WW-1:0] rb1);
    logic [CL-1:0] snap, exp_vec, obs, exp_chain, rbv;
    int base_e, base_rb, t, cnt, gaps, pend, early;
    snap    = chain;
    exp_vec = {w1[LB-1:0], w0};
    base_e  = q_en.size();
    base_rb = q_rb.size();
    rb0 = '0;
    rb1 = '0;

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;

    fork
      begin
        send_word(w0, 0);
        send_word(w1, g1);
        cfg_valid = 1'b0;
      end
      begin
        if (mid_start) begin
          repeat (12) @(negedge clk);
          start = 1'b1;
          @(posedge clk);
          #1 start = 1'b0;
        end
      end
    join

    t = 0;
    while (!done && t < LIM) begin @(negedge clk); t++; end
    check("done_level", 64'(done), 64'(1));
    repeat (4) @(negedge clk);
    check("busy_after", 64'(busy), 64'(0));
    check("ready_after", 64'(cfg_ready), 64'(0));
    check("done_held", 64'(done), 64'(1));

    cnt = 0; gaps = 0; pend = 0; early = 0; obs = '0;
    for (int i = base_e; i < q_en.size(); i++) begin
      if (q_en[i]) begin
        if (cnt < int'(CL)) obs[cnt] = q_in[i];
        cnt++;
        gaps += pend;
        pend = 0;
      end else if (cnt > 0) begin
        pend++;
      end
      if (cnt > 0 && cnt < int'(CL) && !q_busy[i]) early++;
    end
    check("enable_count", 64'(cnt), 64'(CL));
    check("bit_sequence", 64'(obs), 64'(exp_vec));
    check("enable_gaps", 64'(gaps), 64'(g1));
    check("busy_early_drop", 64'(early), 64'(0));

    for (int j = 0; j < int'(CL); j++) exp_chain[CL-1-j] = exp_vec[j];
    check("chain_contents", 64'(chain), 64'(exp_chain));

    for (int j = 0; j < int'(CL); j++) rbv[j] = snap[CL-1-j];
`ifdef PROG_READBACK_EN
    check("rb_word_count", 64'(q_rb.size() - base_rb), 64'(2));
    if (q_rb.size() >= base_rb + 2) begin
      rb0 = q_rb[base_rb];
      rb1 = q_rb[base_rb+1];
    end
    check("rb_word0", 64'(rb0), 64'(rbv[WW-1:0]));
    check("rb_word1", 64'(rb1), 64'({24'd0, rbv[CL-1:WW]}));
`endif
  endtask

  initial begin
    logic [CL-1:0] pre;
    logic [WW-1:0] rb0, rb1, a, b;
    int t;

    prog_rst   = 1'b1;
    start      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_data   = '0;
    chain_load = 1'b1;
    // Old chain contents read back tail first as 0x12345678 then 0x9A.
    pre = {8'h9A, 32'h12345678};
    for (int j = 0; j < int'(CL); j++) chain_init[CL-1-j] = pre[j];
    repeat (3) @(posedge clk);
    #1;
    prog_rst   = 1'b0;
    chain_load = 1'b0;

    @(negedge clk);
    check("rst_cfg_ready", 64'(cfg_ready), 64'(0));
    check("rst_prog_in", 64'(prog_in), 64'(0));
    check("rst_prog_en", 64'(prog_en), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
`ifdef PROG_READBACK_EN
    check("rst_rb_valid", 64'(rb_valid), 64'(0));
    check("rst_rb_data", 64'(rb_data), 64'(0));
`endif

    // Gapless load of the reference words.
    do_load(32'hA5A5A5A5, 32'h000000C3, 0, 1'b0, rb0, rb1);
`ifdef PROG_READBACK_EN
    check("rb_old0", 64'(rb0), 64'(32'h12345678));
    check("rb_old1", 64'(rb1), 64'(32'h0000009A));
`endif

    // Same words with a 3-cycle bubble; readback returns the first load.
    do_load(32'hA5A5A5A5, 32'h000000C3, 3, 1'b0, rb0, rb1);
`ifdef PROG_READBACK_EN
    check("rb_again0", 64'(rb0), 64'(32'hA5A5A5A5));
    check("rb_again1", 64'(rb1), 64'(32'h000000C3));
`endif

    // start while shifting must be ignored.
    do_load($urandom, $urandom, 0, 1'b1, rb0, rb1);

    // Reset part-way through a load, together with start (reset wins).
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cfg_data  = $urandom;
    cfg_valid = 1'b1;
    repeat (11) @(negedge clk);
    check("busy_before_rst", 64'(busy), 64'(1));
    prog_rst = 1'b1;
    start    = 1'b1;
    @(posedge clk);
    #1;
    prog_rst  = 1'b0;
    start     = 1'b0;
    cfg_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_prog_en", 64'(prog_en), 64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_done", 64'(done), 64'(0));
    check("rst_mid_ready", 64'(cfg_ready), 64'(0));
    repeat (3) @(negedge clk);
    check("rst_idle_en", 64'(prog_en), 64'(0));

    do_load($urandom, $urandom, 0, 1'b0, rb0, rb1);

    // Randomised loads with random bubbles and stray starts.
    for (int k = 0; k < 6; k++) begin
      a = $urandom;
      b = $urandom;
      t = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0;
      do_load(a, b, t, $urandom_range(0, 1) == 1, rb0, rb1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
